// File: rtl/decoder_pkg.sv
// Shared types and constants for the binary-to-one-hot decoder.
package decoder_pkg;

    localparam int DEC_IN_W  = 4;
    localparam int DEC_OUT_W = 16;

    typedef logic [DEC_IN_W-1:0]  dec_sel_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    // Reference one-hot decode of the default-width select.
    function automatic dec_onehot_t onehot_decode(input dec_sel_t sel);
        dec_onehot_t res;
        res = {DEC_OUT_W{1'b0}};
        for (int i = 0; i < DEC_OUT_W; i++) begin
            res[i] = (sel == dec_sel_t'(i));
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_checker.sv
// Run-time invariant checks on the registered decoder outputs.
module decoder_checker #(
    parameter int OUT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    input logic [OUT_W-1:0] out_q,
    input logic             valid_q
);

    // A loaded register is one-hot, an unloaded one is all zeros; an X load
    // (unknown select) is deliberately passed through and not flagged.
    property p_out_q_shape;
        @(posedge clk) disable iff (!rst_n)
            $isunknown(out_q) ||
            (valid_q ? $onehot(out_q) : (out_q == {OUT_W{1'b0}}));
    endproperty

    a_out_q_shape: assert property (p_out_q_shape)
        else $error("decoder_checker: out_q shape violated (valid=%0b out_q=%h)", valid_q, out_q);

endmodule

// File: rtl/decoder_onehot_core.sv
// Purely combinational one-hot decode: bit i is set iff sel equals i.
// An unknown select poisons every output bit so no line is silently chosen.
module decoder_onehot_core
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = 2**IN_W
) (
    input  logic [IN_W-1:0]  sel,
    output logic [OUT_W-1:0] onehot
);

    // Reduction XOR of sel with itself is 0 for known inputs and X otherwise;
    // mixing it into each bit forces an all-X result for an X/Z select.
    logic sel_par_s;
    logic xpoison_s;

    assign sel_par_s = ^sel;
    assign xpoison_s = sel_par_s ^ sel_par_s;

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign onehot[i] = (sel == IN_W'(i)) ^ xpoison_s;
    end

endmodule

// File: rtl/decoder.sv
// Binary-to-one-hot decoder with a zero-latency output and a registered,
// load-enabled copy plus valid flag for pipelined consumers.
module decoder
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  decoder_in,
    input  logic             decoder_en,
    output logic [OUT_W-1:0] decoder_out,
    output logic [OUT_W-1:0] decoder_out_q,
    output logic             decoder_valid_q
);

    if (OUT_W != 2**IN_W) begin : g_bad_width
        $error("decoder: OUT_W must equal 2**IN_W");
    end

    logic [OUT_W-1:0] onehot_s;
    logic [OUT_W-1:0] out_q_r;
    logic             valid_r;

    decoder_onehot_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .sel    (decoder_in),
        .onehot (onehot_s)
    );

    assign decoder_out = onehot_s;

    // Load the decoded value and mark it valid when enabled; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_r <= {OUT_W{1'b0}};
            valid_r <= 1'b0;
        end else if (decoder_en) begin
            out_q_r <= onehot_s;
            valid_r <= 1'b1;
        end else begin
            out_q_r <= out_q_r;
            valid_r <= valid_r;
        end
    end

    assign decoder_out_q   = out_q_r;
    assign decoder_valid_q = valid_r;

    decoder_checker #(
        .OUT_W (OUT_W)
    ) u_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .out_q   (out_q_r),
        .valid_q (valid_r)
    );

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed scenarios plus randomized
// stimulus against a shift-based reference model.
`timescale 1ns/1ps
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  decoder_in;
    logic        decoder_en;
    logic [15:0] decoder_out;
    logic [15:0] decoder_out_q;
    logic        decoder_valid_q;

    int checks_n = 0;
    int errors_n = 0;

    // Reference model state for the registered path.
    logic [15:0] model_q;
    logic        model_v;

    decoder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .decoder_in      (decoder_in),
        .decoder_en      (decoder_en),
        .decoder_out     (decoder_out),
        .decoder_out_q   (decoder_out_q),
        .decoder_valid_q (decoder_valid_q)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] ref_onehot(input logic [3:0] v);
        logic [15:0] one;
        one = 16'd1;
        return one << v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic probe;
        logic [3:0] xsel;

        rst_n      = 1'b0;
        decoder_en = 1'b0;
        decoder_in = 4'd0;
        model_q    = 16'h0000;
        model_v    = 1'b0;
        #1;
        check("reset_out_q", decoder_out_q, 16'h0000);
        check("reset_valid", {15'd0, decoder_valid_q}, 16'h0000);

        // Exhaustive combinational sweep, one value every 100 ns.
        for (int i = 0; i < 16; i++) begin
            decoder_in = 4'(i);
            #1;
            check($sformatf("sweep_%0d", i), decoder_out, ref_onehot(4'(i)));
            #99;
        end
        check("sweep_q_in_reset", decoder_out_q, 16'h0000);

        // Registered load of 3.
        @(negedge clk);
        rst_n      = 1'b1;
        decoder_en = 1'b1;
        decoder_in = 4'd3;
        @(posedge clk); #1;
        check("load3_q", decoder_out_q, 16'h0008);
        check("load3_valid", {15'd0, decoder_valid_q}, 16'h0001);

        // Hold with enable low while the input changes.
        @(negedge clk);
        decoder_en = 1'b0;
        decoder_in = 4'd12;
        #1;
        check("hold_comb", decoder_out, 16'h1000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_q_%0d", k), decoder_out_q, 16'h0008);
        end

        // Back-to-back loads.
        decoder_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] vals [3];
            vals = '{4'd14, 4'd0, 4'd9};
            @(negedge clk);
            decoder_in = vals[k];
            @(posedge clk); #1;
            check($sformatf("b2b_%0d", k), decoder_out_q, ref_onehot(vals[k]));
        end

        // Reset asserted mid-cycle clears registered outputs at once.
        @(negedge clk);
        #2;
        decoder_en = 1'b1;
        decoder_in = 4'd7;
        rst_n      = 1'b0;
        #1;
        check("midrst_q", decoder_out_q, 16'h0000);
        check("midrst_valid", {15'd0, decoder_valid_q}, 16'h0000);
        check("midrst_comb", decoder_out, 16'h0080);
        @(posedge clk); #1;
        check("rst_prio_q", decoder_out_q, 16'h0000);

        // Randomized stimulus against the model.
        model_q = 16'h0000;
        model_v = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 19) != 0);
            decoder_en = 1'($urandom_range(0, 1));
            decoder_in = 4'($urandom_range(0, 15));
            #1;
            if (!rst_n) begin
                model_q = 16'h0000;
                model_v = 1'b0;
            end
            check("rnd_comb", decoder_out, ref_onehot(decoder_in));
            @(posedge clk); #1;
            if (rst_n && decoder_en) begin
                model_q = ref_onehot(decoder_in);
                model_v = 1'b1;
            end
            check("rnd_q", decoder_out_q, model_q);
            check("rnd_valid", {15'd0, decoder_valid_q}, {15'd0, model_v});
        end

        // X propagation, only observable on a four-state simulator.
        probe = 1'bx;
        if ($isunknown(probe)) begin
            @(negedge clk);
            rst_n      = 1'b1;
            decoder_en = 1'b1;
            xsel       = 4'b1x00;
            decoder_in = xsel;
            #1;
            check("x_comb", {15'd0, &(decoder_out ^ decoder_out) === 1'bx}, 16'h0001);
            @(posedge clk); #1;
            check("x_q", {15'd0, $isunknown(decoder_out_q)}, 16'h0001);
        end

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
